// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder: state encoding,
// run-length helpers and the lane packing helper used by the skew muxes.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Skewed operands occupy 2N-1 cycles on the array edge.
  function automatic int stream_len(input int n);
    return 2 * n - 1;
  endfunction

  // N register hops to reach PE(N-1,N-1) plus one accumulate cycle.
  function automatic int drain_len(input int n);
    return n + 1;
  endfunction

  // Low bit of element `lane` in a vector of w-bit elements.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_lane_mux.sv
// Selects the element a skewed lane presents at step t: element (t - LANE)
// of the stored row/column, or zero when the lane is outside its window.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int LANE   = 0,
  parameter int T_W    = 3
) (
  input  logic [N*DATA_W-1:0] vec,
  input  logic [T_W-1:0]      step,
  output logic [DATA_W-1:0]   elem
);

  always_comb begin
    elem = '0;
    for (int m = 0; m < N; m++) begin
      if (int'(step) == m + LANE) begin
        elem = vec[lane_lo(m, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit edge of the systolic MAC array: buffers one N x N operand pair,
// clears the array, streams skewed zero-padded A rows / B columns, drains
// the array and pulses done when every product has been accumulated.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [N*DATA_W-1:0] ld_a,
  input  logic [N*DATA_W-1:0] ld_b,
  output logic                pe_clear,
  output logic [N*DATA_W-1:0] out_a,
  output logic [N*DATA_W-1:0] out_b,
  output logic                busy,
  output logic                done
);

  localparam int STREAM_LEN = stream_len(N);
  localparam int DRAIN_LEN  = drain_len(N);
  localparam int BEAT_W     = (N > 1) ? $clog2(N) : 1;
  localparam int STEP_W     = $clog2(2 * N);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ld_ready_q, pe_clear_q, busy_q, done_q;

  // A rows and B columns as delivered by the loader; never reset.
  logic [N*DATA_W-1:0] a_row_q [N];
  logic [N*DATA_W-1:0] b_col_q [N];

  logic                vld_p0;
  logic [N*DATA_W-1:0] lane_a_p0, lane_b_p0;
  logic [N*DATA_W-1:0] out_a_p1, out_b_p1;

  // ---- stage 0: control, operand capture and lane selection ----
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    step_d  = step_q;
    unique case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          if (beat_q == BEAT_W'(N - 1)) begin
            state_d = ST_CLEAR;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
        step_d  = '0;
      end
      ST_STREAM: begin
        if (step_q == STEP_W'(STREAM_LEN - 1)) begin
          state_d = ST_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (step_q == STEP_W'(DRAIN_LEN - 1)) begin
          state_d = ST_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && ld_valid) begin
      a_row_q[beat_q] <= ld_a;
      b_col_q[beat_q] <= ld_b;
    end
  end

  // Lanes are selected for the upcoming cycle so the registered outputs
  // line up with the state they belong to.
  assign vld_p0 = (state_d == ST_STREAM);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_elem, b_elem;

    skew_lane_mux #(.DATA_W(DATA_W), .N(N), .LANE(i), .T_W(STEP_W)) u_lane_a (
      .vec  (a_row_q[i]),
      .step (step_d),
      .elem (a_elem)
    );

    skew_lane_mux #(.DATA_W(DATA_W), .N(N), .LANE(i), .T_W(STEP_W)) u_lane_b (
      .vec  (b_col_q[i]),
      .step (step_d),
      .elem (b_elem)
    );

    assign lane_a_p0[lane_lo(i, DATA_W) +: DATA_W] = vld_p0 ? a_elem : '0;
    assign lane_b_p0[lane_lo(i, DATA_W) +: DATA_W] = vld_p0 ? b_elem : '0;
  end

  // ---- stage 1: registered state and outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      beat_q     <= '0;
      step_q     <= '0;
      ld_ready_q <= 1'b1;
      pe_clear_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_a_p1   <= '0;
      out_b_p1   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      step_q     <= step_d;
      ld_ready_q <= (state_d == ST_LOAD);
      pe_clear_q <= (state_d == ST_CLEAR);
      busy_q     <= (state_d == ST_CLEAR) || (state_d == ST_STREAM) ||
                    (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      out_a_p1   <= lane_a_p0;
      out_b_p1   <= lane_b_p0;
    end
  end

  assign ld_ready = ld_ready_q;
  assign pe_clear = pe_clear_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_a    = out_a_p1;
  assign out_b    = out_b_p1;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: an N=2 and an N=4 instance, each
// driving a behavioural MAC array so final out_C values can be checked.
module tb_systolic_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        vld2, rdy2, clr2, busy2, done2;
  logic [15:0] la2, lb2, oa2, ob2;
  logic        vld4, rdy4, clr4, busy4, done4;
  logic [31:0] la4, lb4, oa4, ob4;

  systolic_feeder #(.DATA_W(8), .N(2)) dut2 (
    .clk(clk), .reset(reset), .ld_valid(vld2), .ld_ready(rdy2),
    .ld_a(la2), .ld_b(lb2), .pe_clear(clr2), .out_a(oa2), .out_b(ob2),
    .busy(busy2), .done(done2)
  );

  systolic_feeder #(.DATA_W(8), .N(4)) dut4 (
    .clk(clk), .reset(reset), .ld_valid(vld4), .ld_ready(rdy4),
    .ld_a(la4), .ld_b(lb4), .pe_clear(clr4), .out_a(oa4), .out_b(ob4),
    .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural MAC arrays: a moves right, b moves down, acc += a*b.
  logic [7:0] pa2 [2][2];
  logic [7:0] pb2 [2][2];
  int         c2  [2][2];
  logic [7:0] pa4 [4][4];
  logic [7:0] pb4 [4][4];
  int         c4  [4][4];

  function automatic logic [7:0] ain2(input int i, input int j);
    if (j == 0) return oa2[i*8 +: 8];
    else        return pa2[i][j-1];
  endfunction
  function automatic logic [7:0] bin2(input int i, input int j);
    if (i == 0) return ob2[j*8 +: 8];
    else        return pb2[i-1][j];
  endfunction
  function automatic logic [7:0] ain4(input int i, input int j);
    if (j == 0) return oa4[i*8 +: 8];
    else        return pa4[i][j-1];
  endfunction
  function automatic logic [7:0] bin4(input int i, input int j);
    if (i == 0) return ob4[j*8 +: 8];
    else        return pb4[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        pa2[i][j] <= ain2(i, j);
        pb2[i][j] <= bin2(i, j);
        c2[i][j]  <= clr2 ? 0 : c2[i][j] + int'(ain2(i, j)) * int'(bin2(i, j));
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        pa4[i][j] <= ain4(i, j);
        pb4[i][j] <= bin4(i, j);
        c4[i][j]  <= clr4 ? 0 : c4[i][j] + int'(ain4(i, j)) * int'(bin4(i, j));
      end
  end

  int clr_cnt4 = 0;
  always @(posedge clk) if (clr4) clr_cnt4 <= clr_cnt4 + 1;

  // Hand-computed N=2 stream for A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  logic [15:0] ea2 [3] = '{16'h0001, 16'h0302, 16'h0400};
  logic [15:0] eb2 [3] = '{16'h0005, 16'h0607, 16'h0800};
  int          ec2 [2][2] = '{'{19, 22}, '{43, 50}};

  int ma [4][4];
  int mb [4][4];
  int expc [4][4];

  function automatic logic [31:0] exp_a4(input int t);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) v[i*8 +: 8] = 8'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_b4(input int t);
    logic [31:0] v = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) v[j*8 +: 8] = 8'(mb[t-j][j]);
    return v;
  endfunction

  task automatic run2(input bit junk);
    @(negedge clk);
    check_eq("n2_ready", rdy2, 1'b1);
    vld2 = 1'b1; la2 = 16'h0201; lb2 = 16'h0705;
    @(negedge clk);
    la2 = 16'h0403; lb2 = 16'h0806;
    @(negedge clk);
    if (junk) begin la2 = 16'hffff; lb2 = 16'hffff; end
    else vld2 = 1'b0;
    check_eq("n2_clear", {clr2, busy2, rdy2, oa2, ob2}, {1'b1, 1'b1, 1'b0, 32'h0});
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check_eq($sformatf("n2_a_t%0d", t), oa2, ea2[t]);
      check_eq($sformatf("n2_b_t%0d", t), ob2, eb2[t]);
      check_eq("n2_stream_ctl", {rdy2, busy2, clr2}, 3'b010);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      vld2 = 1'b0;
      check_eq("n2_drain", {done2, busy2, oa2 | ob2}, {1'b0, 1'b1, 16'h0});
    end
    @(negedge clk);
    check_eq("n2_done", {done2, busy2, rdy2}, 3'b100);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check_eq($sformatf("n2_c%0d%0d", i, j), c2[i][j], ec2[i][j]);
  endtask

  task automatic load4(input bit toggle);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("n4_rdy_k%0d", k), {rdy4, clr4}, 2'b10);
      vld4 = 1'b1;
      for (int m = 0; m < 4; m++) begin
        la4[m*8 +: 8] = 8'(ma[k][m]);
        lb4[m*8 +: 8] = 8'(mb[m][k]);
      end
      if (toggle && k < 3) begin
        @(negedge clk);
        check_eq("n4_gap_noclr", {clr4, rdy4}, 2'b01);
        vld4 = 1'b0; la4 = '1; lb4 = '1;
      end
    end
  endtask

  task automatic stream4();
    @(negedge clk);
    vld4 = 1'b0;
    check_eq("n4_clear", {clr4, busy4, rdy4, oa4}, {1'b1, 1'b1, 1'b0, 32'h0});
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      check_eq($sformatf("n4_a_t%0d", t), oa4, exp_a4(t));
      check_eq($sformatf("n4_b_t%0d", t), ob4, exp_b4(t));
    end
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      check_eq("n4_drain", {done4, busy4, clr4, oa4 | ob4}, {1'b0, 1'b1, 1'b0, 32'h0});
    end
    @(negedge clk);
    check_eq("n4_done", {done4, busy4}, 2'b10);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check_eq($sformatf("n4_c%0d%0d", i, j), c4[i][j], expc[i][j]);
  endtask

  int cnt0;

  initial begin
    reset = 1'b0;
    vld2 = 1'b0; la2 = '0; lb2 = '0;
    vld4 = 1'b0; la4 = '0; lb4 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_n2", {rdy2, busy2, done2, clr2, oa2, ob2}, {4'b1000, 32'h0});
    check_eq("rst_n4", {rdy4, busy4, done4, clr4}, 4'b1000);
    check_eq("rst_n4_lanes", {oa4, ob4}, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    run2(1'b0);
    run2(1'b1);

    // Abort mid-stream with an asynchronous reset.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 9;
        mb[i][j] = 7;
      end
    load4(1'b0);
    @(negedge clk);
    vld4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_t1_busy", {busy4, oa4}, {1'b1, exp_a4(1)});
    #2 reset = 1'b0;
    #1;
    check_eq("abort_async_lanes", {oa4, ob4}, 64'h0);
    check_eq("abort_async_ctl", {busy4, rdy4, done4, clr4}, 4'b0100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_load", {rdy4, busy4, clr4}, 3'b100);
    cnt0 = clr_cnt4;

    // Run A: valid toggled during load, full product check.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 4 * i + j + 1;
        mb[i][j] = i + j;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        expc[i][j] = 0;
        for (int k = 0; k < 4; k++) expc[i][j] += ma[i][k] * mb[k][j];
      end
    load4(1'b1);
    stream4();

    // Run B back-to-back: identity A, so out_C must equal B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j]   = (i == j) ? 1 : 0;
        mb[i][j]   = 4 * i + j + 1;
        expc[i][j] = 4 * i + j + 1;
      end
    load4(1'b0);
    stream4();
    check_eq("n4_clear_pulses", clr_cnt4 - cnt0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
